smash_link_tx: RTL



---
 rtl/smash_pkg.sv | 24 ++
 rtl/smash_link_tx_if.sv | 33 +++
 rtl/smash_credit_cnt.sv | 61 ++++++
 rtl/smash_link_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/smash_pkg.sv
// smash_pkg: shared definitions for the smash link transmit/receive slice.
//   - flit type encodings carried in the two MSBs of every flit
//   - position of the flit type field, counted down from the flit MSB
//   - framing FSM state encoding
package smash_pkg;

    typedef logic [1:0] flit_type_t;

    localparam flit_type_t FLIT_BODY   = 2'b00;
    localparam flit_type_t FLIT_HEAD   = 2'b01;
    localparam flit_type_t FLIT_TAIL   = 2'b10;
    localparam flit_type_t FLIT_SINGLE = 2'b11;

    // The type field sits at [DATA_SIZE-1-FLIT_TYPE_HI : DATA_SIZE-1-FLIT_TYPE_LO],
    // i.e. the MSB and the bit just below it, whatever the flit width.
    localparam int FLIT_TYPE_HI = 0;
    localparam int FLIT_TYPE_LO = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/smash_link_tx_if.sv
// smash_link_tx_if: handshake signals around the link transmitter.
//   Source FIFO side : i_data, i_empty (to tx), o_read (from tx)
//   Link side        : o_flit, o_valid (from tx), i_credit (to tx)
//   master modport   : transmitter view
//   slave modport    : environment view (source FIFO + downstream router)
interface smash_link_tx_if #(
    parameter int DATA_SIZE = 32
);
    logic [DATA_SIZE-1:0] i_data;
    logic                 i_empty;
    logic                 o_read;
    logic [DATA_SIZE-1:0] o_flit;
    logic                 o_valid;
    logic                 i_credit;

    modport master (
        input  i_data,
        input  i_empty,
        input  i_credit,
        output o_read,
        output o_flit,
        output o_valid
    );

    modport slave (
        output i_data,
        output i_empty,
        output i_credit,
        input  o_read,
        input  o_flit,
        input  o_valid
    );
endinterface

// File: rtl/smash_credit_cnt.sv
// smash_credit_cnt: saturating up/down credit counter.
//   i_clk, i_rst : clock, async active-high reset (reloads to MAX)
//   i_inc        : return one credit
//   i_dec        : consume one credit
//   o_count      : registered count
//   o_zero       : count is zero
//   o_ovf        : increment requested while full with no decrement; increment dropped
module smash_credit_cnt #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero,
    output logic         o_ovf
);
    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;
    logic         full_s;

    assign full_s  = (count_r == MAX_C);
    assign o_count = count_r;
    assign o_zero  = (count_r == {W{1'b0}});
    assign o_ovf   = i_inc & ~i_dec & full_s;

    // Next count: simultaneous inc/dec cancel, both ends saturate.
    always_comb begin
        count_next_s = count_r;
        case ({i_inc, i_dec})
            2'b10: begin
                if (!full_s) begin
                    count_next_s = count_r + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    count_next_s = count_r;
                end
            end
            2'b01: begin
                if (!o_zero) begin
                    count_next_s = count_r - {{(W-1){1'b0}}, 1'b1};
                end else begin
                    count_next_s = count_r;
                end
            end
            default: count_next_s = count_r;
        endcase
    end

    // Count register, reloads to MAX on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r <= MAX_C;
        end else begin
            count_r <= count_next_s;
        end
    end
endmodule

// File: rtl/smash_link_tx.sv
// smash_link_tx: credit-based link transmitter with packet framing check.
//   i_clk, i_rst : clock, async active-high reset
//   bus (master) : i_data/i_empty/o_read to the source FIFO,
//                  o_flit/o_valid/i_credit to the downstream router
//   o_credits    : current credit count
//   o_busy       : mid-packet (between HEAD and TAIL)
//   o_err        : one-cycle pulse on a dropped flit or a surplus credit
module smash_link_tx
    import smash_pkg::*;
#(
    parameter  int DATA_SIZE = 32,
    parameter  int CREDITS   = 2,
    localparam int CREDIT_W  = $clog2(CREDITS + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    smash_link_tx_if.master     bus,
    output logic [CREDIT_W-1:0] o_credits,
    output logic                o_busy,
    output logic                o_err
);
    state_t               state_r;
    state_t               state_next_s;
    logic [DATA_SIZE-1:0] flit_r;
    logic                 valid_r;
    logic                 err_r;
    flit_type_t           type_s;
    logic                 legal_s;
    logic                 pop_s;
    logic                 send_s;
    logic                 frame_err_s;
    logic                 credits_zero_s;
    logic                 credit_ovf_s;

    assign type_s      = bus.i_data[DATA_SIZE-1-FLIT_TYPE_HI : DATA_SIZE-1-FLIT_TYPE_LO];
    // Illegal flits are still popped so a malformed entry cannot block the FIFO.
    assign pop_s       = ~bus.i_empty & ~credits_zero_s;
    assign send_s      = pop_s & legal_s;
    assign frame_err_s = pop_s & ~legal_s;

    assign bus.o_read  = pop_s;
    assign bus.o_flit  = flit_r;
    assign bus.o_valid = valid_r;
    assign o_busy      = (state_r == ST_PKT);
    assign o_err       = err_r;

    smash_credit_cnt #(
        .MAX (CREDITS),
        .W   (CREDIT_W)
    ) u_credit_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (bus.i_credit),
        .i_dec   (send_s),
        .o_count (o_credits),
        .o_zero  (credits_zero_s),
        .o_ovf   (credit_ovf_s)
    );

    // Framing legality of the head FIFO entry and the state it leads to.
    always_comb begin
        legal_s      = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                case (type_s)
                    FLIT_HEAD: begin
                        legal_s      = 1'b1;
                        state_next_s = ST_PKT;
                    end
                    FLIT_SINGLE: begin
                        legal_s      = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                    default: begin
                        legal_s      = 1'b0;
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
            ST_PKT: begin
                case (type_s)
                    FLIT_BODY: begin
                        legal_s      = 1'b1;
                        state_next_s = ST_PKT;
                    end
                    FLIT_TAIL: begin
                        legal_s      = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                    default: begin
                        legal_s      = 1'b0;
                        state_next_s = ST_PKT;
                    end
                endcase
            end
            default: begin
                legal_s      = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Framing FSM and registered link outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            flit_r  <= {DATA_SIZE{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= frame_err_s | credit_ovf_s;
            if (send_s) begin
                state_r <= state_next_s;
                flit_r  <= bus.i_data;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end
endmodule
